// File: rtl/icache_assoc.sv
// Set-associative instruction cache (1 or 2 ways, multi-word lines, per-set LRU) between IF and ramctrl.
// Optional ICACHE_FLUSH_EN adds flush_in, which invalidates every line and drops any fill in progress.
module icache_assoc #(
    parameter int ADDR_WIDTH     = 32,
    parameter int INST_WIDTH     = 32,
    parameter int INDEX_WIDTH    = 6,
    parameter int LINE_WORDS_LOG = 2,
    parameter int WAY_COUNT      = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
`ifdef ICACHE_FLUSH_EN
    input  logic                  flush_in,
`endif
    input  logic [ADDR_WIDTH-1:0] if_icache_inst_addr_in,
    output logic                  icache_if_miss_out,
    output logic [INST_WIDTH-1:0] icache_if_inst_inst_out,
    output logic                  icache_ramctrl_en_out,
    output logic [ADDR_WIDTH-1:0] icache_ramctrl_addr_out,
    input  logic                  ramctrl_icache_inst_rdy_in,
    input  logic [INST_WIDTH-1:0] ramctrl_icache_inst_inst_in
);

    localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - LINE_WORDS_LOG - 2;
    localparam int SETS       = 1 << INDEX_WIDTH;
    localparam int LINE_WORDS = 1 << LINE_WORDS_LOG;
    localparam int INDEX_LSB  = LINE_WORDS_LOG + 2;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_WIDTH;
    localparam logic [LINE_WORDS_LOG-1:0] LAST_WORD = LINE_WORDS_LOG'(LINE_WORDS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e                    state_q;
    logic                      en_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [LINE_WORDS_LOG-1:0] wordCnt_q;
    logic                      victim_q;
    logic [INDEX_WIDTH-1:0]    fillIndex_q;
    logic [TAG_WIDTH-1:0]      fillTag_q;

    logic [SETS-1:0]           valid_q [WAY_COUNT];
    logic [SETS-1:0]           lru_q;
    logic [TAG_WIDTH-1:0]      tagArr_q  [WAY_COUNT][SETS];
    logic [INST_WIDTH-1:0]     dataArr_q [WAY_COUNT][SETS][LINE_WORDS];

    logic [TAG_WIDTH-1:0]      addrTag;
    logic [INDEX_WIDTH-1:0]    addrIndex;
    logic [LINE_WORDS_LOG-1:0] addrOffset;
    logic [ADDR_WIDTH-1:0]     lineBase;
    logic                      hit;
    logic                      hitWay;
    logic [INST_WIDTH-1:0]     hitInst;
    logic                      victimSel;
    logic                      freeFound;
    logic                      flushNow;
    logic                      wordWrite;
    logic                      lineDone;
    logic [1:0]                unusedAddrBits;

`ifdef ICACHE_FLUSH_EN
    assign flushNow = flush_in;
`else
    assign flushNow = 1'b0;
`endif

    assign addrTag        = if_icache_inst_addr_in[ADDR_WIDTH-1:TAG_LSB];
    assign addrIndex      = if_icache_inst_addr_in[INDEX_LSB +: INDEX_WIDTH];
    assign addrOffset     = if_icache_inst_addr_in[2 +: LINE_WORDS_LOG];
    assign lineBase       = {if_icache_inst_addr_in[ADDR_WIDTH-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
    assign unusedAddrBits = if_icache_inst_addr_in[1:0];

    always_comb begin
        hit     = 1'b0;
        hitWay  = 1'b0;
        hitInst = '0;
        for (int w = 0; w < WAY_COUNT; w++) begin
            if (valid_q[w][addrIndex] && (tagArr_q[w][addrIndex] == addrTag)) begin
                hit     = 1'b1;
                hitWay  = 1'(w);
                hitInst = dataArr_q[w][addrIndex][addrOffset];
            end
        end
    end

    // Victim: lowest-numbered invalid way first, otherwise the way LRU points at.
    always_comb begin
        victimSel = 1'b0;
        freeFound = 1'b0;
        for (int w = 0; w < WAY_COUNT; w++) begin
            if (!freeFound && !valid_q[w][addrIndex]) begin
                victimSel = 1'(w);
                freeFound = 1'b1;
            end
        end
        if (!freeFound && (WAY_COUNT == 2)) begin
            victimSel = lru_q[addrIndex];
        end
    end

    assign wordWrite = !rst_in && rdy_in && !flushNow && (state_q == FILL) && ramctrl_icache_inst_rdy_in;
    assign lineDone  = wordWrite && (wordCnt_q == LAST_WORD);

    assign icache_if_miss_out      = (state_q != IDLE) || !hit;
    assign icache_if_inst_inst_out = hitInst;
    assign icache_ramctrl_en_out   = en_q;
    assign icache_ramctrl_addr_out = addr_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            addr_q      <= '0;
            wordCnt_q   <= '0;
            victim_q    <= 1'b0;
            fillIndex_q <= '0;
            fillTag_q   <= '0;
            lru_q       <= '0;
            for (int w = 0; w < WAY_COUNT; w++) begin
                valid_q[w] <= '0;
            end
        end else if (rdy_in) begin
            if (flushNow) begin
                state_q <= IDLE;
                en_q    <= 1'b0;
                lru_q   <= '0;
                for (int w = 0; w < WAY_COUNT; w++) begin
                    valid_q[w] <= '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!hit) begin
                            // Invalidate the victim now so a half-written line can never hit.
                            for (int w = 0; w < WAY_COUNT; w++) begin
                                if (victimSel == 1'(w)) begin
                                    valid_q[w][addrIndex] <= 1'b0;
                                end
                            end
                            victim_q    <= victimSel;
                            fillIndex_q <= addrIndex;
                            fillTag_q   <= addrTag;
                            addr_q      <= lineBase;
                            wordCnt_q   <= '0;
                            en_q        <= 1'b1;
                            state_q     <= FILL;
                        end else if (WAY_COUNT == 2) begin
                            lru_q[addrIndex] <= ~hitWay;
                        end
                    end
                    FILL: begin
                        if (ramctrl_icache_inst_rdy_in) begin
                            if (wordCnt_q == LAST_WORD) begin
                                for (int w = 0; w < WAY_COUNT; w++) begin
                                    if (victim_q == 1'(w)) begin
                                        valid_q[w][fillIndex_q] <= 1'b1;
                                    end
                                end
                                if (WAY_COUNT == 2) begin
                                    lru_q[fillIndex_q] <= ~victim_q;
                                end
                                en_q    <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                wordCnt_q <= wordCnt_q + LINE_WORDS_LOG'(1);
                                addr_q    <= addr_q + ADDR_WIDTH'(4);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk_in) begin
        if (wordWrite) begin
            for (int w = 0; w < WAY_COUNT; w++) begin
                if (victim_q == 1'(w)) begin
                    dataArr_q[w][fillIndex_q][wordCnt_q] <= ramctrl_icache_inst_inst_in;
                    if (lineDone) begin
                        tagArr_q[w][fillIndex_q] <= fillTag_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc with a behavioural ramctrl that answers each word 2 cycles after it is requested.
// Exercises the flush port as well when ICACHE_FLUSH_EN is defined.
module tb_icache_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] addr;
    logic        missOut;
    logic [31:0] instOut;
    logic        enOut;
    logic [31:0] addrOut;
    logic        ramRdy;
    logic [31:0] ramData;
`ifdef ICACHE_FLUSH_EN
    logic        flush;
`endif

    int          checksTotal = 0;
    int          checksPassed = 0;
    int          cycleCnt = 0;
    int          waitCnt = 0;
    int          lastPulseCycle = 0;
    int          ramLatency = 2;
    logic [31:0] reqLog [$];

    icache_assoc dut (
        .clk_in                      (clk),
        .rst_in                      (rst),
        .rdy_in                      (rdy),
`ifdef ICACHE_FLUSH_EN
        .flush_in                    (flush),
`endif
        .if_icache_inst_addr_in      (addr),
        .icache_if_miss_out          (missOut),
        .icache_if_inst_inst_out     (instOut),
        .icache_ramctrl_en_out       (enOut),
        .icache_ramctrl_addr_out     (addrOut),
        .ramctrl_icache_inst_rdy_in  (ramRdy),
        .ramctrl_icache_inst_inst_in (ramData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] expWord(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    // Behavioural ramctrl: pulses one word ramLatency cycles after each request, only while rdy is high.
    always begin
        @(posedge clk);
        #2;
        ramRdy = 1'b0;
        if (rst || !enOut) begin
            waitCnt = 0;
        end else if (rdy) begin
            if (waitCnt == ramLatency) begin
                ramRdy  = 1'b1;
                ramData = expWord(addrOut);
                reqLog.push_back(addrOut);
                lastPulseCycle = cycleCnt;
                waitCnt = 0;
            end else begin
                waitCnt++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic r, input logic rs);
        step();
        addr = a;
        rdy  = r;
        rst  = rs;
    endtask

    task automatic waitMissLow(input string tag, output int cyc);
        logic found = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            @(negedge clk);
            if (!missOut) begin
                found = 1'b1;
                cyc   = cycleCnt;
                break;
            end
        end
        checkOutput({tag, "_fill_done"}, {31'd0, found}, 32'd1);
    endtask

    task automatic waitReqCount(input string tag, input int n);
        logic found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            @(negedge clk);
            if (reqLog.size() >= n) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_req_count"}, {31'd0, found}, 32'd1);
    endtask

    task automatic waitEnLevel(input string tag, input logic level, output int cyc);
        logic found = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            @(negedge clk);
            if (enOut === level) begin
                found = 1'b1;
                cyc   = cycleCnt;
                break;
            end
        end
        checkOutput({tag, "_en_level"}, {31'd0, found}, 32'd1);
    endtask

    task automatic runFill(input logic [31:0] a, input string tag);
        int cyc;
        applyStimulus(a, 1'b1, 1'b0);
        waitMissLow(tag, cyc);
        checkOutput({tag, "_word"}, instOut, expWord(a));
    endtask

    task automatic checkHit(input logic [31:0] a, input string tag);
        applyStimulus(a, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_miss"}, {31'd0, missOut}, 32'd0);
        checkOutput({tag, "_word"}, instOut, expWord(a));
    endtask

    task automatic doReset(input logic [31:0] a);
        applyStimulus(a, 1'b1, 1'b1);
        applyStimulus(a, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          cyc;
        int          pulseCyc;
        logic [31:0] logged;
        logic [31:0] hitAddrs [3];

        rst     = 1'b1;
        rdy     = 1'b1;
        addr    = 32'h100;
        ramRdy  = 1'b0;
        ramData = '0;
`ifdef ICACHE_FLUSH_EN
        flush   = 1'b0;
`endif
        repeat (3) step();
        @(negedge clk);
        checkOutput("reset_en", {31'd0, enOut}, 32'd0);
        checkOutput("reset_addr", addrOut, 32'd0);
        checkOutput("reset_miss", {31'd0, missOut}, 32'd1);

        // Cold miss on 0x100
        reqLog.delete();
        applyStimulus(32'h100, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("cold_detect_miss", {31'd0, missOut}, 32'd1);
        checkOutput("cold_detect_en", {31'd0, enOut}, 32'd0);
        step();
        @(negedge clk);
        checkOutput("cold_en_rise", {31'd0, enOut}, 32'd1);
        checkOutput("cold_first_addr", addrOut, 32'h100);
        waitMissLow("cold", cyc);
        checkOutput("cold_req_total", reqLog.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            logged = (i < reqLog.size()) ? reqLog[i] : 32'hDEAD_BEEF;
            checkOutput($sformatf("cold_req_%0d", i), logged, 32'h100 + 32'(4 * i));
        end
        checkOutput("cold_latency", cyc, lastPulseCycle + 1);
        checkOutput("cold_word0", instOut, expWord(32'h100));
        checkOutput("cold_en_after", {31'd0, enOut}, 32'd0);

        // Remaining words of the same line
        hitAddrs = '{32'h104, 32'h108, 32'h10C};
        for (int i = 0; i < 3; i++) begin
            checkHit(hitAddrs[i], $sformatf("line_hit_%0d", i));
            checkOutput($sformatf("line_hit_en_%0d", i), {31'd0, enOut}, 32'd0);
        end

        // Two-way conflict on index 0x10 and LRU eviction
        runFill(32'h500, "fill500");
        checkHit(32'h500, "both_500");
        checkHit(32'h100, "both_100");
        runFill(32'h900, "fill900");
        checkHit(32'h900, "after900_900");
        checkHit(32'h100, "after900_100");
        applyStimulus(32'h500, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("evicted_500_misses", {31'd0, missOut}, 32'd1);
        waitMissLow("refill500", cyc);
        checkOutput("refill500_word", instOut, expWord(32'h500));

        // Stall mid-fill and redirect fetch
        doReset(32'h100);
        reqLog.delete();
        waitReqCount("stall", 2);
        applyStimulus(32'h2000, 1'b0, 1'b0);
        repeat (4) step();
        @(negedge clk);
        checkOutput("stall_addr_frozen", addrOut, 32'h108);
        checkOutput("stall_en_held", {31'd0, enOut}, 32'd1);
        checkOutput("stall_no_pulses", reqLog.size(), 32'd2);
        applyStimulus(32'h2000, 1'b1, 1'b0);
        waitEnLevel("stall_done", 1'b0, cyc);
        pulseCyc = lastPulseCycle;
        checkOutput("stall_req_total", reqLog.size(), 32'd4);
        logged = (reqLog.size() >= 4) ? reqLog[3] : 32'hDEAD_BEEF;
        checkOutput("stall_last_req", logged, 32'h10C);
        waitEnLevel("redirect_start", 1'b1, cyc);
        checkOutput("redirect_addr", addrOut, 32'h2000);
        checkOutput("redirect_bubble", cyc, pulseCyc + 2);
        waitMissLow("redirect", cyc);
        checkOutput("redirect_word", instOut, expWord(32'h2000));
        checkHit(32'h100, "stall_line_kept");

        // Reset in the middle of a fill
        doReset(32'h100);
        reqLog.delete();
        waitReqCount("rstfill", 2);
        applyStimulus(32'h100, 1'b1, 1'b1);
        step();
        @(negedge clk);
        checkOutput("rstfill_en", {31'd0, enOut}, 32'd0);
        checkOutput("rstfill_addr", addrOut, 32'd0);
        applyStimulus(32'h100, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rstfill_misses", {31'd0, missOut}, 32'd1);
        waitMissLow("rstfill_refill", cyc);
        checkOutput("rstfill_refill_word", instOut, expWord(32'h100));

`ifdef ICACHE_FLUSH_EN
        // Flush with 0x100 resident, then flush during the resulting refill
        applyStimulus(32'h100, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_same_cycle_hit", {31'd0, missOut}, 32'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_then_miss", {31'd0, missOut}, 32'd1);
        step();
        @(negedge clk);
        checkOutput("flush_refill_en", {31'd0, enOut}, 32'd1);
        checkOutput("flush_refill_addr", addrOut, 32'h100);
        step();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_fill_en_before", {31'd0, enOut}, 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_drops_fill", {31'd0, enOut}, 32'd0);
        checkOutput("flush_drop_miss", {31'd0, missOut}, 32'd1);
        waitMissLow("flush_refill", cyc);
        checkOutput("flush_refill_word", instOut, expWord(32'h100));
`endif

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
